// File: rtl/cnu_pkg.sv
// Shared types and defaults for the CNU serial arithmetic blocks.
package cnu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;

    localparam int CNU_W_DEFAULT = 8;

endpackage

// File: rtl/FULL_ADDER.sv
// One-bit full adder shared by the bit-serial sequencer.
module FULL_ADDER (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic COUT,
    output logic SUM
);

    assign SUM  = A ^ B ^ CIN;
    assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/cnu_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one FULL_ADDER, LSB first, valid/ready on both sides.
module cnu_serial_add_ctrl
    import cnu_pkg::*;
#(
    parameter int W = CNU_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         busy
);

    localparam int CNT_W = $clog2(W) + 1;

    sadd_state_t    state, state_nxt;
    logic [W-1:0]   a_sr, b_sr, res_sr;
    logic [CNT_W-1:0] bit_cnt;
    logic           carry, cmsb;
    logic           fa_sum, fa_cout;
    logic           accept, last;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last      = (state == RUN) && (bit_cnt == CNT_W'(W - 1));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    FULL_ADDER u_fa (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .CIN  (carry),
        .COUT (fa_cout),
        .SUM  (fa_sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE: begin
                if (accept)         state_nxt = RUN;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bit_cnt  <= '0;
            carry    <= 1'b0;
            cmsb     <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Subtract is A + ~B + 1: invert B up front and seed the carry.
                a_sr    <= in_a;
                b_sr    <= in_sub ? ~in_b : in_b;
                carry   <= in_sub;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                a_sr   <= {1'b0, a_sr[W-1:1]};
                b_sr   <= {1'b0, b_sr[W-1:1]};
                res_sr <= {fa_sum, res_sr[W-1:1]};
                carry  <= fa_cout;
                // Carry out of bit W-2 is the carry into the MSB, needed for signed overflow.
                if (bit_cnt == CNT_W'(W - 2)) cmsb <= fa_cout;
                if (last) begin
                    bit_cnt  <= '0;
                    out_sum  <= {fa_sum, res_sr[W-1:1]};
                    out_cout <= fa_cout;
                    out_ovf  <= cmsb ^ fa_cout;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule
